block_mem_ctrl: RTL and testbench



---
 rtl/block_mem_pkg.sv | 25 ++
 rtl/block_mem_array.sv | 36 +++
 rtl/block_mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_block_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_pkg.sv
// Shared constants and types for the block memory stage that sits
// below the data cache: block geometry, FSM states, MMIO addresses.
package block_mem_pkg;

   // Block geometry as seen by the cache's next-level bus.
   localparam int BLOCK_BITS = 128;
   localparam int OFFSET_W   = $clog2(BLOCK_BITS / 8);
   localparam int LANE_W     = 32;
   localparam int LANES      = BLOCK_BITS / LANE_W;

   // Request/response field widths shared with the cache.
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = BLOCK_BITS;

   // Default memory-mapped word ports used by test programs.
   localparam logic [ADDR_W-1:0] IN0_ADDR_DEF  = 32'h0000_0F00;
   localparam logic [ADDR_W-1:0] OUT0_ADDR_DEF = 32'h0000_0F10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/block_mem_array.sv
// DEPTH x BLOCK_BITS block storage with one synchronous port.
// Ports: clk, rst (sync, clears only the read register), en/we strobe,
//        idx block index, wdata write block, rdata registered read block.
// The storage itself is never cleared so benches can preload "mem".
module block_mem_array #(
   parameter int BLOCK_BITS = block_mem_pkg::BLOCK_BITS,
   parameter int DEPTH      = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [BLOCK_BITS-1:0]    wdata,
   output logic [BLOCK_BITS-1:0]    rdata
);

   logic [BLOCK_BITS-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= wdata;
      end
   end

   // The read register only moves on a read strobe, so it holds the
   // last read block for the whole response phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/block_mem_ctrl.sv
// Main-memory stage below the data cache: whole-block read/write with a
// fixed access latency over a four-phase valid/ready handshake, plus the
// IN0/OUT0 memory-mapped word ports.
// Ports: clk, rst (sync, active-high); req_valid/req_write/req_addr/
//        req_data request; rsp_ready/rsp_data response; busy (not IDLE);
//        in0_data MMIO input word; out0_data last word written to OUT0.
// Optional: define BLOCK_MEM_STATS_EN to add rd_count/wr_count outputs.
module block_mem_ctrl #(
   parameter int          BLOCK_BITS = block_mem_pkg::BLOCK_BITS,
   parameter int          DEPTH      = 256,
   parameter int          LATENCY    = 4,
   parameter logic [31:0] IN0_ADDR   = block_mem_pkg::IN0_ADDR_DEF,
   parameter logic [31:0] OUT0_ADDR  = block_mem_pkg::OUT0_ADDR_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [BLOCK_BITS-1:0] req_data,
   output logic                  rsp_ready,
   output logic [BLOCK_BITS-1:0] rsp_data,
   output logic                  busy,
   input  logic [31:0]           in0_data,
`ifdef BLOCK_MEM_STATS_EN
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count,
`endif
   output logic [31:0]           out0_data
);

   import block_mem_pkg::*;

   localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int NLANE  = BLOCK_BITS / LANE_W;
   localparam int LSEL_W = (NLANE > 1) ? $clog2(NLANE) : 1;
   localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   localparam logic [LSEL_W-1:0] IN0_LANE  = LSEL_W'(IN0_ADDR >> 2);
   localparam logic [LSEL_W-1:0] OUT0_LANE = LSEL_W'(OUT0_ADDR >> 2);

   state_t state;
   state_t state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic accept;
   logic commit;
   logic mem_en;

   // Request captured at accept.
   logic                  lat_write;
   logic [IDX_W-1:0]      lat_idx;
   logic                  lat_in0;
   logic                  lat_out0;
   logic [BLOCK_BITS-1:0] lat_data;

   // Fields of the transaction being committed this edge.
   logic                  cur_write;
   logic [IDX_W-1:0]      cur_idx;
   logic                  cur_in0;
   logic                  cur_out0;
   logic [BLOCK_BITS-1:0] cur_data;

   logic                  req_in0;
   logic                  req_out0;
   logic                  idle;

   // Read-path MMIO overlay state.
   logic [31:0]           in0_q;
   logic                  rd_in0;
   logic [BLOCK_BITS-1:0] rdata;

   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[OFF_W-1:0];

   assign idle     = (state == IDLE);
   assign req_in0  = (req_addr[31:OFF_W] == IN0_ADDR[31:OFF_W]);
   assign req_out0 = (req_addr[31:OFF_W] == OUT0_ADDR[31:OFF_W]);

   // With LATENCY==1 the commit happens on the accepting edge itself,
   // so the live request is used; otherwise the captured copy is.
   assign cur_write = idle ? req_write : lat_write;
   assign cur_idx   = idle ? req_addr[OFF_W +: IDX_W] : lat_idx;
   assign cur_in0   = idle ? req_in0 : lat_in0;
   assign cur_out0  = idle ? req_out0 : lat_out0;
   assign cur_data  = idle ? req_data : lat_data;

   assign busy      = !idle;
   assign rsp_ready = (state == RESP);

   // Reset wins over a commit on the same edge.
   assign mem_en    = commit && !rst;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      commit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  commit   = 1'b1;
                  state_nx = RESP;
               end else begin
                  cnt_nx   = CNT_W'(LATENCY - 2);
                  state_nx = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               commit   = 1'b1;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         RESP: begin
            if (!req_valid) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out0_data <= '0;
         lat_write <= 1'b0;
         lat_idx   <= '0;
         lat_in0   <= 1'b0;
         lat_out0  <= 1'b0;
         lat_data  <= '0;
         in0_q     <= '0;
         rd_in0    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_addr[OFF_W +: IDX_W];
            lat_in0   <= req_in0;
            lat_out0  <= req_out0;
            lat_data  <= req_data;
         end
         if (commit && cur_write && cur_out0) begin
            out0_data <= cur_data[OUT0_LANE*LANE_W +: LANE_W];
         end
         if (commit && !cur_write) begin
            in0_q  <= in0_data;
            rd_in0 <= cur_in0;
         end
      end
   end

   block_mem_array #(
      .BLOCK_BITS (BLOCK_BITS),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .en    (mem_en),
      .we    (cur_write),
      .idx   (cur_idx),
      .wdata (cur_data),
      .rdata (rdata)
   );

   // The IN0 lane of a read always shows the sampled input word,
   // whatever was last stored there.
   always_comb begin
      rsp_data = rdata;
      if (rd_in0) begin
         rsp_data[IN0_LANE*LANE_W +: LANE_W] = in0_q;
      end
   end

`ifdef BLOCK_MEM_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (commit) begin
         if (cur_write) begin
            wr_count <= wr_count + 32'd1;
         end else begin
            rd_count <= rd_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Scoreboard bench for block_mem_ctrl: dut_a at LATENCY=4, dut_b at
// LATENCY=1; directed transactions with hand-computed expectations.
module tb_block_mem_ctrl;

   typedef struct {
      int           dut;
      bit           rd;
      logic [127:0] data;
      int           issue;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]         req_valid;
   logic [1:0]         req_write;
   logic [1:0][31:0]   req_addr;
   logic [1:0][127:0]  req_data;
   logic [1:0]         rsp_ready;
   logic [1:0][127:0]  rsp_data;
   logic [1:0]         busy;
   logic [1:0][31:0]   in0_data;
   logic [1:0][31:0]   out0_data;
`ifdef BLOCK_MEM_STATS_EN
   logic [1:0][31:0]   rd_count;
   logic [1:0][31:0]   wr_count;
`endif

   exp_t sb[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   lat_of[2] = '{4, 1};
   logic [1:0] prev_rdy = 2'b00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   block_mem_ctrl #(.LATENCY(4)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_data(req_data[0]),
      .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
      .busy(busy[0]), .in0_data(in0_data[0]),
`ifdef BLOCK_MEM_STATS_EN
      .rd_count(rd_count[0]), .wr_count(wr_count[0]),
`endif
      .out0_data(out0_data[0])
   );

   block_mem_ctrl #(.LATENCY(1)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_data(req_data[1]),
      .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
      .busy(busy[1]), .in0_data(in0_data[1]),
`ifdef BLOCK_MEM_STATS_EN
      .rd_count(rd_count[1]), .wr_count(wr_count[1]),
`endif
      .out0_data(out0_data[1])
   );

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rising rsp_ready must match the oldest expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (rsp_ready[i] === 1'b1 && prev_rdy[i] !== 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp dut%0d: got rsp_ready 1 expected 0", i);
            end else begin
               e = sb.pop_front();
               check($sformatf("rsp_dut%0d", i), 128'(i), 128'(e.dut));
               check($sformatf("latency_dut%0d", i), 128'(cyc - e.issue),
                     128'(lat_of[i]));
               if (e.rd) begin
                  check($sformatf("rsp_data_dut%0d", i), rsp_data[i], e.data);
               end
            end
         end
      end
      prev_rdy = rsp_ready;
   end

   task automatic xact(input int d, input bit wr, input logic [31:0] addr,
                       input logic [127:0] data, input logic [127:0] expd);
      exp_t e;
      @(posedge clk); #1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_data[d]  = data;
      req_valid[d] = 1'b1;
      e.dut   = d;
      e.rd    = !wr;
      e.data  = expd;
      e.issue = cyc;
      sb.push_back(e);
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (n == 0) begin
            // Inputs after accept must be ignored.
            req_write[d] = ~wr;
            req_addr[d]  = ~addr;
            req_data[d]  = ~data;
         end
         if (rsp_ready[d]) break;
      end
      if (!rsp_ready[d]) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d: got rsp_ready 0 expected 1", d);
      end
      req_valid[d] = 1'b0;
      @(posedge clk); #1;
      check("rsp_drop", 128'(rsp_ready[d]), 128'(0));
      check("busy_idle", 128'(busy[d]), 128'(0));
   endtask

   localparam logic [127:0] P0   = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [127:0] P32  = 128'h32323232_32323232_32323232_32323232;
   localparam logic [127:0] PIN  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
   localparam logic [127:0] W256 = 128'hAABBCCDD_EEFF0011_22334455_66778899;
   localparam logic [127:0] WALS = 128'h10001000_A1A1A1A1_B2B2B2B2_C3C3C3C3;
   localparam logic [127:0] W4   = 128'h44440003_44440002_44440001_44440000;
   localparam logic [127:0] WOUT = 128'h11112222_33334444_55556666_DEADBEEF;
   localparam logic [127:0] WB   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_data  = '0;
      in0_data  = '0;
      dut_a.u_array.mem[0]   = P0;
      dut_a.u_array.mem[32]  = P32;
      dut_a.u_array.mem[240] = PIN;
      dut_b.u_array.mem[0]   = P0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 2; i++) begin
         check("reset_rsp_ready", 128'(rsp_ready[i]), 128'(0));
         check("reset_busy", 128'(busy[i]), 128'(0));
         check("reset_rsp_data", rsp_data[i], 128'(0));
         check("reset_out0", 128'(out0_data[i]), 128'(0));
      end

      // Plain read, offset bits ignored.
      xact(0, 1'b0, 32'h0000_0008, '0, P0);
      // Write then read back, neighbour untouched.
      xact(0, 1'b1, 32'h0000_0100, W256, '0);
      xact(0, 1'b0, 32'h0000_0104, '0, W256);
      xact(0, 1'b0, 32'h0000_0000, '0, P0);
      // Address aliasing past DEPTH blocks.
      xact(0, 1'b1, 32'h0000_1000, WALS, '0);
      xact(0, 1'b0, 32'h0000_0000, '0, WALS);
      // IN0 overlays lane 0 of its block.
      in0_data[0] = 32'h5A5A_0001;
      xact(0, 1'b0, 32'h0000_0F00, '0,
           128'hCAFE0003_CAFE0002_CAFE0001_5A5A0001);
      xact(0, 1'b1, 32'h0000_0F00, W4, '0);
      xact(0, 1'b0, 32'h0000_0F04, '0,
           128'h44440003_44440002_44440001_5A5A0001);
      // OUT0 captures lane 0 of the written block.
      xact(0, 1'b1, 32'h0000_0F10, WOUT, '0);
      check("out0_data", 128'(out0_data[0]), 128'(32'hDEAD_BEEF));

      // Reset during WAIT of a write aborts it.
      @(posedge clk); #1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'd512;
      req_data[0]  = ~P32;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      check("busy_wait", 128'(busy[0]), 128'(1));
      rst          = 1'b1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("busy_after_rst", 128'(busy[0]), 128'(0));
      check("rdy_after_rst", 128'(rsp_ready[0]), 128'(0));
      check("out0_after_rst", 128'(out0_data[0]), 128'(0));
      repeat (4) @(posedge clk);
      xact(0, 1'b0, 32'd512, '0, P32);

      // LATENCY=1 back-to-back read/write/read.
      xact(1, 1'b0, 32'h0000_0000, '0, P0);
      xact(1, 1'b1, 32'h0000_0010, WB, '0);
      xact(1, 1'b0, 32'h0000_0010, '0, WB);
`ifdef BLOCK_MEM_STATS_EN
      check("rd_count", 128'(rd_count[1]), 128'(2));
      check("wr_count", 128'(wr_count[1]), 128'(1));
`endif

      for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
      check("sb_empty", 128'(sb.size()), 128'(0));
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
